// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter between scanout reader and host writer.
// Ports:
//   i_clk, i_rstn              pixel clock, async active-low reset
//   i_vblank                   vertical blanking (writer priority while high)
//   i_rd_req/i_rd_addr         scanout read request, o_rd_gnt accept strobe
//   o_rd_valid/o_rd_data       read data return, two cycles after grant
//   i_wr_req/i_wr_addr/i_wr_data  host write request, o_wr_gnt accept strobe
//   o_mem_*                    registered single-port RAM command
//   i_mem_rdata                RAM read data, one cycle after a read command
module fb_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_vblank,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  typedef enum logic [1:0] {S_VIDEO, S_BLANK, S_FORCE} state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_we_q, rd_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  always_comb begin
    o_rd_gnt = i_rstn && i_rd_req && (state_q == S_VIDEO || (state_q == S_BLANK && !i_wr_req));
    o_wr_gnt = i_rstn && i_wr_req && (state_q != S_VIDEO || !i_rd_req);
    // Only a denied writer in video mode accumulates; every other case clears.
    cnt_d = (state_q == S_VIDEO && i_wr_req && !o_wr_gnt) ? (cnt_q == LIMIT ? cnt_q : cnt_q + 8'd1) : 8'd0;
    // cnt_d can reach LIMIT only from S_VIDEO, so force outranks vblank and
    // the other states simply follow i_vblank.
    state_d = cnt_d == LIMIT ? S_FORCE : i_vblank ? S_BLANK : S_VIDEO;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_VIDEO;
      cnt_q       <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= o_rd_gnt | o_wr_gnt;
      mem_we_q   <= o_wr_gnt;
      mem_addr_q <= o_wr_gnt ? i_wr_addr : o_rd_gnt ? i_rd_addr : mem_addr_q;
      mem_wdata_q <= o_wr_gnt ? i_wr_data : mem_wdata_q;
      // RAM data lands the cycle after a read command; flag it then.
      rd_valid_q <= mem_en_q & ~mem_we_q;
    end
  end
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = i_mem_rdata;
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: framebuffer word-address width.
REQ-002 Parameter DATA_W, default 16: framebuffer word width.
REQ-003 Parameter STARVE_LIMIT, default 8: consecutive denied writer-request cycles that force a write grant (range 1..255).
REQ-004 i_clk  in  1  single clock (pixel clock domain); all logic rising-edge.
REQ-005 i_rstn  in  1  reset, asynchronous, active-low.
REQ-006 i_vblank  in  1  high during vertical blanking; selects writer-priority mode.
REQ-007 i_rd_req / i_rd_addr  in  1 / ADDR_W  scanout read request with address, held until granted.
REQ-008 o_rd_gnt  out  1  read request accepted this cycle.
REQ-009 o_rd_valid / o_rd_data  out  1 / DATA_W  read data return strobe and data.
REQ-010 i_wr_req / i_wr_addr / i_wr_data  in  1 / ADDR_W / DATA_W  host write request, held until granted.
REQ-011 o_wr_gnt  out  1  write request accepted this cycle.
REQ-012 o_mem_en / o_mem_we / o_mem_addr / o_mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port RAM command, registered.
REQ-013 i_mem_rdata  in  DATA_W  RAM read data, valid one cycle after o_mem_en with o_mem_we=0.

Function
REQ-014 FSM states: S_VIDEO (reader priority), S_BLANK (writer priority), S_FORCE (one-cycle forced write).
REQ-015 o_rd_gnt and o_wr_gnt are combinational from current state and requests; at most one is high per cycle.
REQ-016 S_VIDEO: grant reader if i_rd_req; else grant writer if i_wr_req.
REQ-017 S_BLANK: grant writer if i_wr_req; else grant reader if i_rd_req.
REQ-018 S_FORCE: grant writer if i_wr_req; reader never granted; exactly one cycle long.
REQ-019 Starve counter (8 bit): increments each S_VIDEO cycle with i_wr_req=1 and o_wr_gnt=0; clears on any write grant, on i_wr_req=0, and in S_BLANK; saturates at STARVE_LIMIT.
REQ-020 Transitions: S_VIDEO->S_FORCE when counter next value equals STARVE_LIMIT; S_VIDEO->S_BLANK when i_vblank=1; S_BLANK->S_VIDEO when i_vblank=0; S_FORCE->S_BLANK if i_vblank=1 else S_VIDEO. Force takes precedence over vblank entry.
REQ-021 Grant in cycle N: o_mem_en=1 in cycle N+1 with o_mem_we=1 for write (addr/wdata captured at N) or o_mem_we=0 for read (addr captured at N); o_mem_en=0 in cycles with no grant.
REQ-022 Read latency: o_rd_valid=1 in cycle N+2 for a read granted in cycle N; o_rd_data equals i_mem_rdata in that cycle; exactly one valid pulse per read grant, in grant order.
REQ-023 Back-to-back grants sustain one access per cycle; alternating read/write grants impose no bubble.
REQ-024 Requester must not change addr/data while req high and ungranted; arbiter behaviour is undefined if violated.
REQ-025 o_mem_addr/o_mem_wdata hold last value when o_mem_en=0.

Reset
REQ-026 On i_rstn=0, immediately: state S_VIDEO, starve counter 0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_rd_valid=0; o_rd_gnt=o_wr_gnt=0 while reset is asserted.
REQ-027 Reads in flight at reset assertion produce no o_rd_valid after release.
REQ-028 First grant possible in the first cycle after i_rstn deasserts.

Verification
REQ-029 S_VIDEO, rd_req and wr_req both high continuously, STARVE_LIMIT=8 -> 8 read grants, then 1 forced write grant, pattern repeats every 9 cycles.
REQ-030 Read addr 0x012 granted at cycle N, RAM model returns 0xBEEF -> o_mem_en=1/we=0/addr=0x012 at N+1, o_rd_valid=1 with data 0xBEEF at N+2.
REQ-031 i_vblank=1, both requesting -> writer granted every cycle, reader only when wr_req drops; i_vblank falls -> reader regains priority next cycle.
REQ-032 Counter at STARVE_LIMIT-1 and i_vblank rises same cycle -> S_FORCE for one cycle, then S_BLANK.
REQ-033 Assert i_rstn=0 one cycle after a read grant -> all outputs 0 asynchronously, no o_rd_valid after release.
REQ-034 Random rd/wr traffic vs. RAM reference model -> every read returns last written value, no grant collisions, no write lost.
